pwr_watchdog_nch: RTL and testbench
===================================

Name: pwr_watchdog_nch

Overview:
- Parametrised successor of the 3-channel power controller.
- Supervises N_CH UUT supply relays plus one GND relay.
- Per channel: synchronises the overload input, runs an over-current timeout on a shared 50 Hz tick, drives a status LED and gates all relays off on any trip or emergency stop.
- Relay requests and timeouts come from the sub-bus 2 I2C slaves; trip status and fault clear are exposed for the executor.

Parameters:
- N_CH, 3, number of supervised supply channels (1..8).
- TMR_W, 8, timeout counter width in ticks.

Ports:
- clk  in  1  system clock (RC oscillator domain).
- RESET  in  1  asynchronous active-low reset.
- tick  in  1  one-clk strobe, 50 Hz timer time base.
- blink_fast  in  1  fast flash pattern (overload warning).
- blink_slow  in  1  slow flash pattern (tripped).
- relay_req  in  N_CH  per-channel relay request, active high.
- gnd_req  in  1  GND relay request, active high.
- ch_en  in  N_CH  per-channel supervision enable; 0 means the channel never trips.
- overload_n  in  N_CH  asynchronous overload comparator inputs, active low.
- tmo_preload  in  N_CH*TMR_W  per-channel timeout in ticks; channel i occupies bits [i*TMR_W +: TMR_W].
- emrgcy_off  in  1  emergency power off, active high, asynchronous.
- fault_clr  in  1  synchronous one-clk pulse; clears trips.
- pwr  out  N_CH  relay drive.
- pwr_gnd  out  1  GND relay drive.
- led  out  N_CH  channel status LEDs.
- trip_flags  out  N_CH  sticky record of tripped channels.
- uut_pwr_fail  out  1  high while alert is active.

Behaviour:
- Reset values: all outputs 0, channel FSMs in OFF, counters at all ones, synchronisers hold 1 (no overload).
- Synchronisers: overload_n and emrgcy_off each pass through 2 flip-flops. ovl[i] = !sync(overload_n[i]).
- Channel FSM, evaluated every clk:
  - OFF: stay while relay_req=0. If relay_req=1 and ovl=0, go to ON. If relay_req=1, ovl=1 and ch_en=1, go to WARN and load cnt<=preload.
  - ON: relay_req=0 goes to OFF. ovl=1 and ch_en=1 goes to WARN and loads cnt.
  - WARN: relay_req=0 goes to OFF. ovl=0 goes to ON. ch_en=0 goes to ON. On tick: if cnt==0 go to TRIP, else cnt<=cnt-1. Trip therefore occurs on tick number preload+1 after entry. preload=0 trips on the first tick.
  - TRIP: relay_req=0 goes to LATCHED. Stays otherwise, even after ovl clears.
  - LATCHED: holds until fault_clr.
- fault_clr pulse: TRIP and LATCHED go to OFF; trip_flags cleared. Priority over all other transitions in the same cycle.
- trip_flags[i] is set on entry to TRIP. When a set and fault_clr coincide, clear wins and the set re-occurs next evaluation.
- alert = OR over channels of (state==TRIP), OR synchronised emrgcy_off. It is combinational from registered state.
- Output register (1 clk after alert/state):
  - If alert: pwr=0 and pwr_gnd=0.
  - Else: pwr=relay_req and pwr_gnd=gnd_req.
  - uut_pwr_fail=alert.
- LED register, per channel:
  - OFF: 0.
  - ON: !alert (steady on; dark while any alert).
  - WARN: blink_fast.
  - TRIP or LATCHED: blink_slow.
- Latency: overload_n edge to state change is 3 clk. State change to pwr is 1 further clk.
- ch_en changed mid-WARN: takes effect next clk. A tripped channel stays tripped regardless of ch_en.
- RESET mid-operation: immediate return to reset values, including all trips.
- tick coincident with ovl dropping: ovl wins and the channel goes to ON (no trip).

Decomposition:
- Package pwr_wd_pkg:
  - channel state enum (OFF, ON, WARN, TRIP, LATCHED), 3-bit encoding.
  - LED source select constants.
  - N_CH maximum constant.
- Sub-module pwr_wd_channel: synchroniser, FSM, counter and LED mux for one channel. Instantiated N_CH times via generate.
- Top level holds the alert OR, emrgcy synchroniser, output register and trip_flags.

Test Plan:
- Reset, relay_req=3'b101, gnd_req=1, no overload -> pwr=101 and pwr_gnd=1 after 1 clk. led=101. uut_pwr_fail=0.
- Ch1 requested, preload=5, overload_n[1] held low -> led[1]=blink_fast. Trip on tick 6. Next clk: pwr=000, pwr_gnd=0, uut_pwr_fail=1, trip_flags=010, led[1]=blink_slow, led[0]=0.
- Ch0 overload for 3 ticks with preload=5, then released -> back to ON with no trip. A new overload reloads 5.
- Tripped ch1, relay_req[1] then dropped -> LATCHED, uut_pwr_fail=0, other relays restored. fault_clr -> led[1]=0, trip_flags=000.
- emrgcy_off=1 for 1 clk or more -> all pwr=0 and uut_pwr_fail=1 within 3 clk. Release -> relays restored 3 clk later with no trip flags.
- ch_en[2]=0 with persistent overload -> no trip, led[2]=1. preload=0 with ch_en=1 -> trip on first tick.

Source files
------------

// File: rtl/pwr_wd_pkg.sv
// Shared types and constants for the N-channel power watchdog.
// Channel states, LED source selection and the supported channel limit.
package pwr_wd_pkg;

  localparam int N_CH_MAX = 8;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ON      = 3'd1,
    ST_WARN    = 3'd2,
    ST_TRIP    = 3'd3,
    ST_LATCHED = 3'd4
  } ch_state_e;

  localparam logic [1:0] LED_DARK   = 2'd0;
  localparam logic [1:0] LED_STEADY = 2'd1;
  localparam logic [1:0] LED_FAST   = 2'd2;
  localparam logic [1:0] LED_SLOW   = 2'd3;

  // Which pattern a channel LED shows in a given state
  function automatic logic [1:0] led_source(input ch_state_e st);
    case (st)
      ST_ON:               return LED_STEADY;
      ST_WARN:             return LED_FAST;
      ST_TRIP, ST_LATCHED: return LED_SLOW;
      default:             return LED_DARK;
    endcase
  endfunction

endpackage

// File: rtl/pwr_wd_channel.sv
// One supervised supply channel: overload synchroniser, over-current
// timeout FSM and status LED register.
import pwr_wd_pkg::*;

module pwr_wd_channel #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             blink_fast,
  input  logic             blink_slow,
  input  logic             relay_req,
  input  logic             ch_en,
  input  logic             overload_n,
  input  logic [TMR_W-1:0] preload,
  input  logic             fault_clr,
  input  logic             alert,
  output logic             tripped,
  output logic             led
);

  logic [1:0]       ovl_sync;
  logic             ovl;
  ch_state_e        state;
  logic [TMR_W-1:0] cnt;

  // Comparator output is asynchronous; reset value means "no overload"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_sync <= 2'b11;
    end else begin
      ovl_sync <= {ovl_sync[0], overload_n};
    end
  end

  assign ovl     = ~ovl_sync[1];
  assign tripped = (state == ST_TRIP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      cnt   <= '1;
      led   <= 1'b0;
    end else begin
      case (led_source(state))
        LED_STEADY: led <= ~alert;
        LED_FAST:   led <= blink_fast;
        LED_SLOW:   led <= blink_slow;
        default:    led <= 1'b0;
      endcase

      // A clear pulse releases a tripped channel ahead of anything else
      if (fault_clr && (state == ST_TRIP || state == ST_LATCHED)) begin
        state <= ST_OFF;
      end else begin
        case (state)
          ST_OFF: begin
            if (relay_req) begin
              if (ovl && ch_en) begin
                state <= ST_WARN;
                cnt   <= preload;
              end else begin
                state <= ST_ON;
              end
            end
          end
          ST_ON: begin
            if (!relay_req) begin
              state <= ST_OFF;
            end else if (ovl && ch_en) begin
              state <= ST_WARN;
              cnt   <= preload;
            end
          end
          // Overload release outranks a coincident tick, so no trip then
          ST_WARN: begin
            if (!relay_req) begin
              state <= ST_OFF;
            end else if (!ovl || !ch_en) begin
              state <= ST_ON;
            end else if (tick) begin
              if (cnt == '0) begin
                state <= ST_TRIP;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          ST_TRIP: begin
            if (!relay_req) begin
              state <= ST_LATCHED;
            end
          end
          ST_LATCHED: begin
            state <= ST_LATCHED;
          end
          default: begin
            state <= ST_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pwr_watchdog_nch.sv
// Top of the N-channel power watchdog: channel array, emergency-off
// synchroniser, alert, relay output register and sticky trip flags.
import pwr_wd_pkg::*;

module pwr_watchdog_nch #(
  parameter int N_CH  = 3,
  parameter int TMR_W = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  tick,
  input  logic                  blink_fast,
  input  logic                  blink_slow,
  input  logic [N_CH-1:0]       relay_req,
  input  logic                  gnd_req,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       overload_n,
  input  logic [N_CH*TMR_W-1:0] tmo_preload,
  input  logic                  emrgcy_off,
  input  logic                  fault_clr,
  output logic [N_CH-1:0]       pwr,
  output logic                  pwr_gnd,
  output logic [N_CH-1:0]       led,
  output logic [N_CH-1:0]       trip_flags,
  output logic                  uut_pwr_fail
);

  logic [1:0]      emrg_sync;
  logic            emrg;
  logic [N_CH-1:0] in_trip;
  logic            alert;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      emrg_sync <= 2'b00;
    end else begin
      emrg_sync <= {emrg_sync[0], emrgcy_off};
    end
  end

  assign emrg  = emrg_sync[1];
  assign alert = (|in_trip) | emrg;

  // Channels past the supported maximum are tied off and never trip
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (i < N_CH_MAX) begin : g_live
      pwr_wd_channel #(
        .TMR_W(TMR_W)
      ) u_ch (
        .clk       (clk),
        .rst_n     (RESET),
        .tick      (tick),
        .blink_fast(blink_fast),
        .blink_slow(blink_slow),
        .relay_req (relay_req[i]),
        .ch_en     (ch_en[i]),
        .overload_n(overload_n[i]),
        .preload   (tmo_preload[i*TMR_W +: TMR_W]),
        .fault_clr (fault_clr),
        .alert     (alert),
        .tripped   (in_trip[i]),
        .led       (led[i])
      );
    end else begin : g_tie
      assign in_trip[i] = 1'b0;
      assign led[i]     = 1'b0;
    end
  end

  // Any alert drops every relay; a clear pulse wins over a fresh trip
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      pwr          <= '0;
      pwr_gnd      <= 1'b0;
      uut_pwr_fail <= 1'b0;
      trip_flags   <= '0;
    end else begin
      pwr          <= alert ? '0 : relay_req;
      pwr_gnd      <= ~alert & gnd_req;
      uut_pwr_fail <= alert;
      trip_flags   <= fault_clr ? '0 : (trip_flags | in_trip);
    end
  end

endmodule

// File: tb/tb_pwr_watchdog_nch.sv
// Scoreboard bench for pwr_watchdog_nch: expectations are queued with a due
// cycle when stimulus is driven and compared by a negedge monitor.
module tb_pwr_watchdog_nch;

  localparam int N_CH  = 3;
  localparam int TMR_W = 8;

  localparam int F_PWR  = 0;
  localparam int F_GND  = 1;
  localparam int F_FAIL = 2;
  localparam int F_TRIP = 3;
  localparam int F_LED  = 4;

  logic                  clk;
  logic                  RESET;
  logic                  tick;
  logic                  blink_fast;
  logic                  blink_slow;
  logic [N_CH-1:0]       relay_req;
  logic                  gnd_req;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       overload_n;
  logic [N_CH*TMR_W-1:0] tmo_preload;
  logic                  emrgcy_off;
  logic                  fault_clr;
  logic [N_CH-1:0]       pwr;
  logic                  pwr_gnd;
  logic [N_CH-1:0]       led;
  logic [N_CH-1:0]       trip_flags;
  logic                  uut_pwr_fail;

  typedef struct {
    string      tag;
    int         due;
    int         field;
    logic [7:0] mask;
    logic [7:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   cycle;
  int   checks;
  int   failures;

  pwr_watchdog_nch #(
    .N_CH (N_CH),
    .TMR_W(TMR_W)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .tick        (tick),
    .blink_fast  (blink_fast),
    .blink_slow  (blink_slow),
    .relay_req   (relay_req),
    .gnd_req     (gnd_req),
    .ch_en       (ch_en),
    .overload_n  (overload_n),
    .tmo_preload (tmo_preload),
    .emrgcy_off  (emrgcy_off),
    .fault_clr   (fault_clr),
    .pwr         (pwr),
    .pwr_gnd     (pwr_gnd),
    .led         (led),
    .trip_flags  (trip_flags),
    .uut_pwr_fail(uut_pwr_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [7:0] observe(input int field);
    case (field)
      F_PWR:   return {5'b0, pwr};
      F_GND:   return {7'b0, pwr_gnd};
      F_FAIL:  return {7'b0, uut_pwr_fail};
      F_TRIP:  return {5'b0, trip_flags};
      default: return {5'b0, led};
    endcase
  endfunction

  // Queue an expectation that must hold k posedges after now
  task automatic expectAt(input string tag, input int field, input logic [7:0] mask,
                          input logic [7:0] value, input int k);
    exp_t e;
    e.tag   = tag;
    e.due   = cycle + k;
    e.field = field;
    e.mask  = mask;
    e.value = value;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cycle) begin
        checkOutput(sb_q[i].tag, observe(sb_q[i].field) & sb_q[i].mask,
                    sb_q[i].value & sb_q[i].mask);
        sb_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseTick(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] req, input logic gnd,
                               input logic [N_CH-1:0] en, input logic [N_CH-1:0] ovn);
    relay_req  = req;
    gnd_req    = gnd;
    ch_en      = en;
    overload_n = ovn;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    RESET       = 1'b1;
    tick        = 1'b0;
    blink_fast  = 1'b0;
    blink_slow  = 1'b1;
    emrgcy_off  = 1'b0;
    fault_clr   = 1'b0;
    tmo_preload = {8'd0, 8'd5, 8'd5};
    applyStimulus(3'b000, 1'b0, 3'b111, 3'b111);
    #2 RESET = 1'b0;
    step(2);

    expectAt("rst_pwr", F_PWR, 8'hff, 8'h0, 1);
    expectAt("rst_gnd", F_GND, 8'hff, 8'h0, 1);
    expectAt("rst_fail", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("rst_trip", F_TRIP, 8'hff, 8'h0, 1);
    expectAt("rst_led", F_LED, 8'hff, 8'h0, 1);
    step(2);
    RESET = 1'b1;
    step(1);

    // Basic relay pass-through
    applyStimulus(3'b101, 1'b1, 3'b111, 3'b111);
    expectAt("on_pwr", F_PWR, 8'hff, 8'h5, 1);
    expectAt("on_gnd", F_GND, 8'hff, 8'h1, 1);
    expectAt("on_fail", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("on_led", F_LED, 8'hff, 8'h5, 2);
    step(3);

    // Ch1 overload with preload 5 trips on the sixth tick
    applyStimulus(3'b111, 1'b1, 3'b111, 3'b111);
    step(3);
    overload_n = 3'b101;
    expectAt("warn_led1", F_LED, 8'h02, 8'h0, 4);
    expectAt("warn_fail", F_FAIL, 8'hff, 8'h0, 4);
    step(4);
    pulseTick(5);
    expectAt("tick5_fail", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("tick5_trip", F_TRIP, 8'hff, 8'h0, 1);
    step(1);
    tick = 1'b1;
    expectAt("tick6_fail_early", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("trip_pwr", F_PWR, 8'hff, 8'h0, 2);
    expectAt("trip_gnd", F_GND, 8'hff, 8'h0, 2);
    expectAt("trip_fail", F_FAIL, 8'hff, 8'h1, 2);
    expectAt("trip_flags", F_TRIP, 8'hff, 8'h2, 2);
    expectAt("trip_led", F_LED, 8'hff, 8'h2, 2);
    step(1);
    tick = 1'b0;
    step(2);

    // Dropping the request latches ch1 and restores the others
    relay_req = 3'b101;
    expectAt("latch_pwr_hold", F_PWR, 8'hff, 8'h0, 1);
    expectAt("latch_pwr", F_PWR, 8'hff, 8'h5, 2);
    expectAt("latch_gnd", F_GND, 8'hff, 8'h1, 2);
    expectAt("latch_fail", F_FAIL, 8'hff, 8'h0, 2);
    expectAt("latch_flags", F_TRIP, 8'hff, 8'h2, 2);
    expectAt("latch_led", F_LED, 8'hff, 8'h7, 2);
    step(3);
    overload_n = 3'b111;
    step(3);
    fault_clr = 1'b1;
    expectAt("clr_flags", F_TRIP, 8'hff, 8'h0, 1);
    expectAt("clr_led1", F_LED, 8'h02, 8'h0, 2);
    step(1);
    fault_clr = 1'b0;
    step(3);

    // Ch0 overload released after 3 ticks, then a fresh overload reloads
    overload_n = 3'b110;
    step(4);
    pulseTick(3);
    overload_n = 3'b111;
    expectAt("rel_led0", F_LED, 8'h01, 8'h1, 4);
    expectAt("rel_fail", F_FAIL, 8'hff, 8'h0, 4);
    expectAt("rel_trip", F_TRIP, 8'hff, 8'h0, 4);
    step(5);
    overload_n = 3'b110;
    step(4);
    pulseTick(5);
    expectAt("reload_fail", F_FAIL, 8'hff, 8'h0, 1);
    step(1);
    tick = 1'b1;
    expectAt("reload_trip_pwr", F_PWR, 8'hff, 8'h0, 2);
    expectAt("reload_trip_flags", F_TRIP, 8'hff, 8'h1, 2);
    expectAt("reload_trip_led", F_LED, 8'hff, 8'h1, 2);
    step(1);
    tick = 1'b0;
    overload_n = 3'b111;
    step(4);
    fault_clr = 1'b1;
    expectAt("clr0_flags", F_TRIP, 8'hff, 8'h0, 1);
    expectAt("clr0_pwr", F_PWR, 8'hff, 8'h5, 2);
    expectAt("clr0_fail", F_FAIL, 8'hff, 8'h0, 2);
    expectAt("clr0_led", F_LED, 8'hff, 8'h5, 3);
    step(1);
    fault_clr = 1'b0;
    step(4);

    // One-clk emergency off
    emrgcy_off = 1'b1;
    expectAt("emrg_pwr_pre", F_PWR, 8'hff, 8'h5, 2);
    expectAt("emrg_pwr", F_PWR, 8'hff, 8'h0, 3);
    expectAt("emrg_gnd", F_GND, 8'hff, 8'h0, 3);
    expectAt("emrg_fail", F_FAIL, 8'hff, 8'h1, 3);
    expectAt("emrg_led", F_LED, 8'hff, 8'h0, 3);
    expectAt("emrg_rel_pwr", F_PWR, 8'hff, 8'h5, 4);
    expectAt("emrg_rel_gnd", F_GND, 8'hff, 8'h1, 4);
    expectAt("emrg_rel_fail", F_FAIL, 8'hff, 8'h0, 4);
    expectAt("emrg_rel_trip", F_TRIP, 8'hff, 8'h0, 4);
    expectAt("emrg_rel_led", F_LED, 8'hff, 8'h5, 4);
    step(1);
    emrgcy_off = 1'b0;
    step(6);

    // Disabled channel ignores a persistent overload
    applyStimulus(3'b111, 1'b1, 3'b011, 3'b011);
    step(4);
    pulseTick(8);
    expectAt("dis_fail", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("dis_trip", F_TRIP, 8'hff, 8'h0, 1);
    expectAt("dis_led", F_LED, 8'hff, 8'h7, 1);
    expectAt("dis_pwr", F_PWR, 8'hff, 8'h7, 1);
    step(2);

    // Re-enabling with preload 0 trips on the very first tick
    ch_en = 3'b111;
    expectAt("p0_warn_led2", F_LED, 8'h04, 8'h0, 2);
    expectAt("p0_warn_fail", F_FAIL, 8'hff, 8'h0, 3);
    step(3);
    tick = 1'b1;
    expectAt("p0_fail_early", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("p0_fail", F_FAIL, 8'hff, 8'h1, 2);
    expectAt("p0_flags", F_TRIP, 8'hff, 8'h4, 2);
    expectAt("p0_pwr", F_PWR, 8'hff, 8'h0, 2);
    step(1);
    tick = 1'b0;
    step(3);

    // Reset mid-operation clears the trip immediately
    RESET = 1'b0;
    expectAt("mid_rst_pwr", F_PWR, 8'hff, 8'h0, 1);
    expectAt("mid_rst_fail", F_FAIL, 8'hff, 8'h0, 1);
    expectAt("mid_rst_trip", F_TRIP, 8'hff, 8'h0, 1);
    expectAt("mid_rst_led", F_LED, 8'hff, 8'h0, 1);
    step(3);
    RESET = 1'b1;
    overload_n = 3'b111;
    expectAt("post_rst_pwr", F_PWR, 8'hff, 8'h7, 1);
    expectAt("post_rst_gnd", F_GND, 8'hff, 8'h1, 1);
    expectAt("post_rst_led", F_LED, 8'hff, 8'h7, 2);
    step(4);

    checkOutput("sb_drain", 8'(sb_q.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
